single_loop: RTL and testbench

- Per-loop iteration tracker for the control unit's hardware loop stack.
- Latches a loop's trip count at reset and counts iterations as the end-of-loop instruction jumps back.
- Raises done while the final iteration executes.
- Inner independent loops are executed superscalar, so they advance 2^SUPERSCALAR_LOG_WIDTH iterations per jump.

---
 rtl/single_loop.sv | 46 ++++
 tb/tb_single_loop.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/single_loop.sv
// Iteration tracker for one hardware-loop stack entry.
// Ports: clk, reset, should_increment, initial_iteration_count,
//   initial_is_inner_independent_loop, jumped -> done, current_iteration.
module single_loop #(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            should_increment,
  input  logic [BITS-1:0] initial_iteration_count,
  input  logic            initial_is_inner_independent_loop,
  input  logic            jumped,
  output logic            done,
  output logic [BITS-1:0] current_iteration
);

  localparam logic [BITS-1:0] WIDE_STEP =
    BITS'(1) << SUPERSCALAR_LOG_WIDTH;

  logic [BITS-1:0] count_q;
  logic            indep_q;
  logic [BITS-1:0] step;
  logic [BITS:0]   next_sum;
  logic            last;

  assign step = indep_q ? WIDE_STEP : BITS'(1);

  // One extra bit so index + step never wraps near the top of the range.
  assign next_sum = {1'b0, current_iteration} + {1'b0, step};
  assign last     = next_sum >= {1'b0, count_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q           <= initial_iteration_count;
      indep_q           <= initial_is_inner_independent_loop;
      current_iteration <= '0;
      done              <= 1'b0;
    end else begin
      done <= last;
      if (should_increment && jumped && !last)
        current_iteration <= next_sum[BITS-1:0];
    end
  end

endmodule

// File: tb/tb_single_loop.sv
// Directed self-checking bench for single_loop.
// Each scenario task drives vectors and checks inline.
module tb_single_loop;

  localparam int BITS = 18;

  logic            clk = 1'b0;
  logic            reset;
  logic            should_increment;
  logic [BITS-1:0] initial_iteration_count;
  logic            initial_is_inner_independent_loop;
  logic            jumped;
  logic            done;
  logic [BITS-1:0] current_iteration;

  int checks = 0;
  int errors = 0;

  single_loop #(
    .BITS(BITS),
    .SUPERSCALAR_LOG_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .should_increment(should_increment),
    .initial_iteration_count(initial_iteration_count),
    .initial_is_inner_independent_loop(initial_is_inner_independent_loop),
    .jumped(jumped),
    .done(done),
    .current_iteration(current_iteration)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    jumped = 1'b1;
    tick(1);
    jumped = 1'b0;
  endtask

  task automatic do_reset(input logic [BITS-1:0] cnt, input logic ind);
    initial_iteration_count = cnt;
    initial_is_inner_independent_loop = ind;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(18'd3, 1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %0b want 0", done);
    end
    checks++;
    if (current_iteration !== 18'd0) begin
      errors++;
      $display("FAIL reset_idx got %0d want 0", current_iteration);
    end
  endtask

  task automatic test_simple();
    do_reset(18'd3, 1'b0);
    for (int p = 0; p < 2; p++) begin
      tick(3);
      checks++;
      if (current_iteration !== BITS'(p) || done !== 1'b0) begin
        errors++;
        $display("FAIL simple_pre%0d got idx %0d done %0b want idx %0d done 0",
                 p, current_iteration, done, p);
      end
      pulse();
      checks++;
      if (current_iteration !== BITS'(p + 1) || done !== 1'b0) begin
        errors++;
        $display("FAIL simple_post%0d got idx %0d done %0b want idx %0d done 0",
                 p, current_iteration, done, p + 1);
      end
    end
    tick(3);
    checks++;
    if (done !== 1'b1 || current_iteration !== 18'd2) begin
      errors++;
      $display("FAIL simple_done got idx %0d done %0b want idx 2 done 1",
               current_iteration, done);
    end
    tick(2);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL simple_hold got done %0b want 1", done);
    end
  endtask

  task automatic test_reset_after_done();
    reset = 1'b1;
    jumped = 1'b1;
    should_increment = 1'b0;
    tick(1);
    reset = 1'b0;
    jumped = 1'b0;
    should_increment = 1'b1;
    checks++;
    if (done !== 1'b0 || current_iteration !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid got idx %0d done %0b want idx 0 done 0",
               current_iteration, done);
    end
    tick(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got done %0b want 0", done);
    end
  endtask

  task automatic test_independent();
    do_reset(18'd12, 1'b1);
    tick(1);
    pulse();
    checks++;
    if (current_iteration !== 18'd4 || done !== 1'b0) begin
      errors++;
      $display("FAIL indep_j1 got idx %0d done %0b want idx 4 done 0",
               current_iteration, done);
    end
    tick(1);
    pulse();
    checks++;
    if (current_iteration !== 18'd8) begin
      errors++;
      $display("FAIL indep_j2 got idx %0d want 8", current_iteration);
    end
    tick(1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL indep_done got done %0b want 1", done);
    end
    pulse();
    checks++;
    if (current_iteration !== 18'd8 || done !== 1'b1) begin
      errors++;
      $display("FAIL indep_late_jump got idx %0d done %0b want idx 8 done 1",
               current_iteration, done);
    end
  endtask

  task automatic test_gating();
    do_reset(18'd3, 1'b0);
    should_increment = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      pulse();
    end
    checks++;
    if (current_iteration !== 18'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL gate got idx %0d done %0b want idx 0 done 0",
               current_iteration, done);
    end
    should_increment = 1'b1;
    pulse();
    checks++;
    if (current_iteration !== 18'd1) begin
      errors++;
      $display("FAIL gate_release got idx %0d want 1", current_iteration);
    end
  endtask

  task automatic test_edge_counts();
    do_reset(18'd1, 1'b0);
    tick(2);
    checks++;
    if (done !== 1'b1 || current_iteration !== 18'd0) begin
      errors++;
      $display("FAIL cnt1 got idx %0d done %0b want idx 0 done 1",
               current_iteration, done);
    end
    do_reset(18'd10, 1'b1);
    pulse();
    pulse();
    tick(1);
    checks++;
    if (done !== 1'b1 || current_iteration !== 18'd8) begin
      errors++;
      $display("FAIL cnt10 got idx %0d done %0b want idx 8 done 1",
               current_iteration, done);
    end
    do_reset(18'd0, 1'b0);
    tick(2);
    checks++;
    if (done !== 1'b1 || current_iteration !== 18'd0) begin
      errors++;
      $display("FAIL cnt0 got idx %0d done %0b want idx 0 done 1",
               current_iteration, done);
    end
    pulse();
    checks++;
    if (current_iteration !== 18'd0) begin
      errors++;
      $display("FAIL cnt0_jump got idx %0d want 0", current_iteration);
    end
  endtask

  initial begin
    reset = 1'b1;
    should_increment = 1'b1;
    jumped = 1'b0;
    initial_iteration_count = '0;
    initial_is_inner_independent_loop = 1'b0;
    tick(2);
    test_reset();
    test_simple();
    test_reset_after_done();
    test_independent();
    test_gating();
    test_edge_counts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
